// File: rtl/rotl_pkg.sv
// rotl_pkg: shared types and helpers for the iterative left rotator.
//   state_t  - controller state encoding (IDLE, ROT, DONE)
//   rotl_by  - rotate a word of 'width' bits left by 'shift' positions;
//              the word is carried in a ROTL_MAX_W-bit container so one
//              function serves every instantiated data width N.
package rotl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROT  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ROTL_MAX_W = 64;
    localparam int ROTL_IDX_W = $clog2(ROTL_MAX_W);

    // Bits at or above 'width' are ignored on input and returned as zero.
    function automatic logic [ROTL_MAX_W-1:0] rotl_by(
        input logic [ROTL_MAX_W-1:0] data,
        input int                    shift,
        input int                    width
    );
        logic [ROTL_MAX_W-1:0] r;
        logic [ROTL_IDX_W-1:0] dst;
        r   = '0;
        dst = '0;
        for (int i = 0; i < ROTL_MAX_W; i++) begin
            if (i < width) begin
                dst    = ROTL_IDX_W'((i + shift) % width);
                r[dst] = data[ROTL_IDX_W'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rotl_iter_stage.sv
// rotl_stage: one fixed-distance stage of the rotator.
//   data_in  [N-1:0]  word entering the stage
//   enable            1 = rotate left by S, 0 = pass through
//   data_out [N-1:0]  stage result
module rotl_stage
    import rotl_pkg::*;
#(
    parameter int N = 8,
    parameter int S = 1
) (
    input  logic [N-1:0] data_in,
    input  logic         enable,
    output logic [N-1:0] data_out
);

    assign data_out = enable ? N'(rotl_by(ROTL_MAX_W'(data_in), S, N)) : data_in;

endmodule

// File: rtl/rotl_iter.sv
// rotl_iter: iterative left rotator, one amount bit per clock, MSB stage first.
// Undoes a right rotation on the return path: rotl(rotr(x,k),k) == x.
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          request handshake (in_bits, in_amount)
//   out_valid/out_ready        result handshake (out_bits)
//   busy                       high while a request is in flight
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// ROT   | applying stage 'stage_q' (M-1 down to 0), one per clock
// DONE  | result on out_bits, out_valid high until out_ready
module rotl_iter
    import rotl_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_bits,
    input  logic [M-1:0] in_amount,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_bits,
    output logic         busy
);

    localparam int SW = (M > 1) ? $clog2(M) : 1;

    state_t        state_q, state_d;
    logic [N-1:0]  data_q;
    logic [M-1:0]  amount_q;
    logic [SW-1:0] stage_q;
    logic [N-1:0]  stage_out [M];
    logic [N-1:0]  rot_data;

    // Stage g rotates by 2**g when amount bit g is set.
    for (genvar g = 0; g < M; g++) begin : g_stage
        rotl_stage #(
            .N (N),
            .S (2**g)
        ) u_stage (
            .data_in  (data_q),
            .enable   (amount_q[g]),
            .data_out (stage_out[g])
        );
    end

    always_comb begin
        rot_data = data_q;
        for (int i = 0; i < M; i++) begin
            if (stage_q == SW'(i)) begin
                rot_data = stage_out[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid)         state_d = ROT;
            ROT:  if (stage_q == '0)    state_d = DONE;
            DONE: if (out_ready)        state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            amount_q <= '0;
            stage_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_bits;
                        amount_q <= in_amount;
                        stage_q  <= SW'(M - 1);
                    end
                end
                ROT: begin
                    data_q <= rot_data;
                    if (stage_q != '0) begin
                        stage_q <= stage_q - SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshakes come from registered state only.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_bits  = data_q;

endmodule

// File: tb/tb_rotl_iter.sv
module tb_rotl_iter;

    localparam int N = 8;
    localparam int M = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_bits;
    logic [M-1:0] in_amount;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_bits;
    logic         busy;

    rotl_iter #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bits   (in_bits),
        .in_amount (in_amount),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_vec  = 0;
    int           n_err  = 0;
    logic [N-1:0] exp_q[$];
    time          t_accept;
    time          t_prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rotr8(input logic [N-1:0] x, input int k);
        logic [2*N-1:0] d;
        d = {x, x};
        return d[k +: N];
    endfunction

    // Monitor: a transfer happens on the next rising edge when both are high.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: got 0x%0h, expected no transfer at %0t", out_bits, $time);
            end else begin
                logic [N-1:0] e;
                e = exp_q.pop_front();
                if (out_bits !== e) begin
                    n_err++;
                    $display("FAIL out_bits: got 0x%0h, expected 0x%0h at %0t", out_bits, e, $time);
                end
            end
        end
    end

    // Waits for in_ready, then presents one request; returns just after the accept edge.
    task automatic issue(input logic [N-1:0] w, input logic [M-1:0] a, input logic [N-1:0] e);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("in_ready_wait", {31'd0, ok}, 32'd1);
        in_valid  = 1'b1;
        in_bits   = w;
        in_amount = a;
        exp_q.push_back(e);
        @(posedge clk);
        t_accept = $time;
        #1;
        in_valid = 1'b0;
    endtask

    // Returns the number of cycles from accept until out_valid is seen.
    task automatic wait_valid(output int cnt);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            cnt++;
            if (out_valid) break;
        end
    endtask

    task automatic run_one(input logic [N-1:0] w, input logic [M-1:0] a, input logic [N-1:0] e);
        int lat;
        out_ready = 1'b1;
        issue(w, a, e);
        wait_valid(lat);
        check("latency", lat, M);
        @(posedge clk); #1;
        check("in_ready_after", {31'd0, in_ready}, 32'd1);
        check("out_valid_after", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_bits   = 8'hFF;
        in_amount = 3'd1;
        out_ready = 1'b1;

        // Reset held with a pending request: nothing may be accepted.
        #2;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_bits", {24'd0, out_bits}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_hold_busy", {31'd0, busy}, 32'd0);
        check("rst_hold_bits", {24'd0, out_bits}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic and boundary amounts.
        run_one(8'hB4, 3'd3, 8'hA5);
        run_one(8'h3C, 3'd4, 8'hC3);
        run_one(8'h01, 3'd7, 8'h80);
        run_one(8'h5A, 3'd0, 8'h5A);

        // Backpressure with an ignored request during DONE.
        out_ready = 1'b0;
        issue(8'hB4, 3'd3, 8'hA5);
        wait_valid(lat);
        check("bp_latency", lat, M);
        in_valid  = 1'b1;
        in_bits   = 8'hFF;
        in_amount = 3'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_out_bits", {24'd0, out_bits}, 32'hA5);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_ready", {31'd0, in_ready}, 32'd1);
        check("bp_queue_empty", exp_q.size(), 0);

        // Reset during the second ROT cycle.
        issue(8'hB4, 3'd3, 8'hA5);
        @(posedge clk); #1;
        rst_n = 1'b0;
        void'(exp_q.pop_back());
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_out_bits", {24'd0, out_bits}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_one(8'h01, 3'd1, 8'h02);

        // Round-trip sweep, back to back.
        out_ready = 1'b1;
        t_prev = 0;
        for (int k = 0; k < 8; k++) begin
            for (int w = 0; w < 256; w++) begin
                issue(rotr8(N'(w), k), M'(k), N'(w));
                if (t_prev != 0) begin
                    check("interval", 32'(t_accept - t_prev), 32'((M + 2) * 10));
                end
                t_prev = t_accept;
            end
        end
        repeat (M + 3) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        check("final_idle", {31'd0, in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
